stream_axi4_writer: RTL
=======================

// Module: stream_axi4_writer
// PURPOSE
//  Slave (consumer) end of the `stream` interface: accepts tdata beats and writes them to memory as AXI4 master INCR write bursts.
//  Software programs base address and beat count, then pulses start; done/err report completion.
//  Sits between a stream producer and the AXI4 interconnect slave port.
// PARAMETERS
//  DATA_WIDTH  64  stream/AXI data width, power of two, 32..512
//  ADDR_WIDTH  32  AXI address width
//  ID_WIDTH    4   AXI ID width; AWID driven constant 0
//  BURST_LEN   16  max beats per burst (1..256); BURST_LEN*DATA_WIDTH/8 <= 4096
//  FIFO_DEPTH  32  input buffer depth, power of two, >= BURST_LEN
// PORTS
//  ACLK        in   1           clock
//  ARESET      in   1           async reset, active-high
//  cfg_start   in   1           one-cycle start pulse, ignored while busy
//  cfg_addr    in   ADDR_WIDTH  base byte address, aligned to BURST_LEN*DATA_WIDTH/8
//  cfg_beats   in   32          total beats to write; 0 = immediate done
//  busy        out  1           transfer in progress
//  done        out  1           one-cycle pulse at completion
//  err         out  1           sticky: any BRESP != OKAY this transfer; cleared on start
//  tdata       in   DATA_WIDTH  stream slave data
//  tvalid      in   1           stream slave valid
//  tready      out  1           stream slave ready
//  AW*/W*/B*   AXI4 master write channels (AWADDR,AWLEN,AWSIZE,AWBURST,AWID,AWVALID,AWREADY,WDATA,WSTRB,WLAST,WVALID,WREADY,BID,BRESP,BVALID,BREADY)
// BEHAVIOUR
//  Reset: busy=0 done=0 err=0 tready=0 AWVALID=0 WVALID=0 WLAST=0 BREADY=0; FIFO emptied, counters 0.
//  Constants: AWSIZE=log2(DATA_WIDTH/8), AWBURST=2'b01, AWID=0, WSTRB all ones; AWCACHE=4'b0011, AWPROT=0, AWQOS=0, AWREGION=0, AWLOCK=0.
//  Stream: beat accepted when tvalid&tready; tready = busy & FIFO not full & accepted < cfg_beats. Beats beyond count are stalled.
//  FSM: IDLE -> (start) ADDR -> DATA -> RESP -> ADDR or DONE -> IDLE.
//   IDLE: start & beats!=0 latches addr/beats, clears err, busy=1, goes to ADDR. start & beats==0: done pulse, stays IDLE.
//   ADDR: burst size n = min(BURST_LEN, remaining). AWVALID rises only once FIFO count >= n (no W-stalling bursts).
//         AWADDR = current addr, AWLEN = n-1. Holds stable until AWREADY.
//   DATA: WVALID = FIFO not empty, WDATA = FIFO head, pop on WVALID&WREADY; WLAST on n-th beat. After last handshake -> RESP.
//   RESP: BREADY=1; on BVALID: err |= (BRESP!=2'b00); addr += n*DATA_WIDTH/8; remaining -= n;
//         remaining==0 -> DONE else ADDR.
//   DONE: done=1 one cycle, busy=0 -> IDLE.
//  One outstanding burst; AW precedes W (no W before AW handshake). Throughput: 1 beat/cycle in DATA when FIFO non-empty and WREADY.
//  Address increments with wrap at 2^ADDR_WIDTH (no saturation); alignment guarantees no 4 KB crossing.
//  Simultaneous FIFO push and pop in the same cycle allowed, count unchanged; push blocked when full, pop never on empty.
//  Reset mid-transfer: all state returns to reset values immediately; outstanding AXI transaction is abandoned (system-level reset).
//  BID ignored. Latency start -> AWVALID: 1 cycle after FIFO holds n beats.
// STRUCTURE
//  Package stream_axi4_pkg: state enum typedef (IDLE,ADDR,DATA,RESP,DONE), AXI_BURST_INCR, AXI_RESP_OKAY, AWCACHE constant.
//  Sub-module: stream_sync_fifo (DATA_WIDTH, FIFO_DEPTH; push/pop/full/empty/count).
//  Top: FSM, addr/remaining/beat counters, accepted-beat counter, AXI drive logic.
// TESTING
//  1 cfg_addr=0x1000, beats=16, BURST_LEN=16, stream full rate, AWREADY/WREADY=1 -> one AW AWLEN=15 @0x1000, 16 W, WLAST on beat 16, done, err=0.
//  2 beats=40, BURST_LEN=16, DATA_WIDTH=64 -> AW @0x1000/0x1080/0x1100, AWLEN 15/15/7, done after 3rd B.
//  3 random tvalid/WREADY/AWREADY backpressure, beats=100 -> memory model matches input sequence exactly, AW/W signals stable while stalled.
//  4 BRESP=2'b10 on 2nd of 3 bursts -> err=1 at done, remaining bursts still issued; next start clears err.
//  5 beats=0 -> done pulse 1 cycle after start, no AW; start while busy -> ignored.
//  6 ARESET asserted mid-DATA -> next cycle all outputs at reset values, FIFO empty; new start works normally.

Source files
------------

// File: rtl/stream_axi4_pkg.sv
// Shared types and AXI constants for the stream-to-AXI4 write path.
package stream_axi4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_AWCACHE    = 4'b0011;

  // Beats in the next burst: the full burst length, or whatever is left.
  function automatic logic [8:0] burst_beats(input logic [31:0] remaining,
                                             input int unsigned max_len);
    if (remaining >= 32'(max_len)) begin
      return 9'(max_len);
    end
    return remaining[8:0];
  endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Synchronous FIFO with a registered head (show-ahead) output.
// The head register is refreshed every cycle from the slot that will be at
// the front after this cycle's pop; a write into that very slot is bypassed.
module stream_sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 32,
  localparam int PW        = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [PW:0]           count
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] head_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [PW-1:0]         rd_ptr_next;
  logic [PW:0]           count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full        = (count_reg == (PW+1)'(FIFO_DEPTH));
  assign empty       = (count_reg == '0);
  assign count       = count_reg;
  assign head        = head_reg;
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign rd_ptr_next = do_pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

  // Pointer and occupancy bookkeeping; push and pop together leave count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Registered read of the next head, with bypass when writing into that slot.
  always_ff @(posedge clk) begin
    if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
      head_reg <= push_data;
    end else begin
      head_reg <= mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/stream_axi4_writer.sv
// Stream consumer that writes accepted beats to memory as AXI4 INCR bursts.
// One burst is outstanding at a time; an address is only issued once the
// whole burst is already buffered so the W channel never stalls on input.
module stream_axi4_writer
  import stream_axi4_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cfg_start,
  input  logic [ADDR_WIDTH-1:0]   cfg_addr,
  input  logic [31:0]             cfg_beats,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic [DATA_WIDTH-1:0]   tdata,
  input  logic                    tvalid,
  output logic                    tready,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic [ID_WIDTH-1:0]     AWID,
  output logic [3:0]              AWCACHE,
  output logic [2:0]              AWPROT,
  output logic [3:0]              AWQOS,
  output logic [3:0]              AWREGION,
  output logic                    AWLOCK,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [ID_WIDTH-1:0]     BID,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int CW    = $clog2(FIFO_DEPTH);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [31:0]           remaining_reg, remaining_next;
  logic [31:0]           beats_reg, beats_next;
  logic [31:0]           accepted_reg, accepted_next;
  logic [8:0]            wbeat_reg, wbeat_next;
  logic                  err_reg, err_next;
  logic                  awvalid_reg, awvalid_next;
  logic                  zero_done_reg, zero_done_next;

  logic [8:0]            burst_n;
  logic [ADDR_WIDTH-1:0] burst_bytes;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW:0]           fifo_count;
  logic                  w_hs;
  logic                  unused_bid;

  assign unused_bid  = ^BID;
  assign burst_n     = burst_beats(remaining_reg, BURST_LEN);
  assign burst_bytes = ADDR_WIDTH'(burst_n) << SZ;

  stream_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (ACLK),
    .rst       (ARESET),
    .push      (fifo_push),
    .push_data (tdata),
    .pop       (fifo_pop),
    .head      (WDATA),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Status and stream handshake.
  assign busy      = (state_reg == ST_ADDR) || (state_reg == ST_DATA) || (state_reg == ST_RESP);
  assign done      = (state_reg == ST_DONE) || zero_done_reg;
  assign err       = err_reg;
  assign tready    = busy && !fifo_full && (accepted_reg < beats_reg);
  assign fifo_push = tvalid && tready;

  // AXI write channels.
  assign AWADDR   = addr_reg;
  assign AWLEN    = 8'(burst_n - 9'd1);
  assign AWSIZE   = 3'(SZ);
  assign AWBURST  = AXI_BURST_INCR;
  assign AWID     = '0;
  assign AWCACHE  = AXI_AWCACHE;
  assign AWPROT   = 3'b000;
  assign AWQOS    = 4'b0000;
  assign AWREGION = 4'b0000;
  assign AWLOCK   = 1'b0;
  assign AWVALID  = awvalid_reg;
  assign WVALID   = (state_reg == ST_DATA) && !fifo_empty;
  assign WLAST    = (state_reg == ST_DATA) && (wbeat_reg == burst_n - 9'd1);
  assign BREADY   = (state_reg == ST_RESP);
  assign w_hs     = WVALID && WREADY;

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_wstrb
    assign WSTRB[gi] = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      beats_reg     <= '0;
      accepted_reg  <= '0;
      wbeat_reg     <= '0;
      err_reg       <= 1'b0;
      awvalid_reg   <= 1'b0;
      zero_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      beats_reg     <= beats_next;
      accepted_reg  <= accepted_next;
      wbeat_reg     <= wbeat_next;
      err_reg       <= err_next;
      awvalid_reg   <= awvalid_next;
      zero_done_reg <= zero_done_next;
    end
  end

  // Next-state logic: sequences address, data and response phases per burst.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    beats_next     = beats_reg;
    accepted_next  = accepted_reg;
    wbeat_next     = wbeat_reg;
    err_next       = err_reg;
    awvalid_next   = awvalid_reg;
    zero_done_next = 1'b0;
    fifo_pop       = 1'b0;

    if (fifo_push) begin
      accepted_next = accepted_reg + 32'd1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_beats == 32'd0) begin
            zero_done_next = 1'b1;
          end else begin
            addr_next      = cfg_addr;
            remaining_next = cfg_beats;
            beats_next     = cfg_beats;
            accepted_next  = 32'd0;
            err_next       = 1'b0;
            state_next     = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (awvalid_reg) begin
          if (AWREADY) begin
            awvalid_next = 1'b0;
            wbeat_next   = 9'd0;
            state_next   = ST_DATA;
          end
        end else if (32'(fifo_count) >= 32'(burst_n)) begin
          awvalid_next = 1'b1;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          fifo_pop   = 1'b1;
          wbeat_next = wbeat_reg + 9'd1;
          if (WLAST) begin
            state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (BVALID) begin
          if (BRESP != AXI_RESP_OKAY) begin
            err_next = 1'b1;
          end
          addr_next      = addr_reg + burst_bytes;
          remaining_next = remaining_reg - 32'(burst_n);
          state_next     = (remaining_reg == 32'(burst_n)) ? ST_DONE : ST_ADDR;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
